// File: rtl/btn_tick_debounce.sv
// Push-button conditioner: 2-flop synchroniser, strobe-timed debounce, and press/release/long events.
// All timing is measured in 1 kHz strobes, so the raw clock frequency never enters the thresholds.
module btn_tick_debounce #(
   parameter int DEBOUNCE_MS = 20,
   parameter int LONG_MS     = 1000,
   parameter int CNT_W       = 10,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_pls_1k,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_hold
);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_DB,
      HELD,
      LONG_HELD,
      RELEASE_DB
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_MS - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] db_cnt, db_cnt_nx;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
   logic             level_nx, hold_nx, press_nx, release_nx, long_nx;
   logic             sync_1, sync_2, btn_s;

   // Synchroniser idles at the released pin level so reset never looks like a press.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         sync_1 <= ACTIVE_LOW;
         sync_2 <= ACTIVE_LOW;
      end else begin
         sync_1 <= i_btn;
         sync_2 <= sync_1;
      end
   end

   assign btn_s = sync_2 ^ ACTIVE_LOW;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state     <= IDLE;
         db_cnt    <= '0;
         hold_cnt  <= '0;
         o_level   <= 1'b0;
         o_hold    <= 1'b0;
         o_press   <= 1'b0;
         o_release <= 1'b0;
         o_long    <= 1'b0;
      end else begin
         state     <= state_nx;
         db_cnt    <= db_cnt_nx;
         hold_cnt  <= hold_cnt_nx;
         o_level   <= level_nx;
         o_hold    <= hold_nx;
         o_press   <= press_nx;
         o_release <= release_nx;
         o_long    <= long_nx;
      end
   end

   // A change of btn_s always takes priority over a coincident strobe, which then goes uncounted.
   always_comb begin
      state_nx    = state;
      db_cnt_nx   = db_cnt;
      hold_cnt_nx = hold_cnt;
      level_nx    = o_level;
      hold_nx     = o_hold;
      press_nx    = 1'b0;
      release_nx  = 1'b0;
      long_nx     = 1'b0;
      case (state)
         IDLE: begin
            if (btn_s) begin
               state_nx  = PRESS_DB;
               db_cnt_nx = '0;
            end
         end
         PRESS_DB: begin
            if (!btn_s) begin
               state_nx = IDLE;
            end else if (i_pls_1k) begin
               if (db_cnt == DB_LAST) begin
                  state_nx    = HELD;
                  level_nx    = 1'b1;
                  press_nx    = 1'b1;
                  hold_cnt_nx = '0;
               end else begin
                  db_cnt_nx = db_cnt + CNT_W'(1);
               end
            end
         end
         HELD: begin
            if (!btn_s) begin
               state_nx  = RELEASE_DB;
               db_cnt_nx = '0;
            end else if (i_pls_1k) begin
               if (hold_cnt == LONG_LAST) begin
                  state_nx = LONG_HELD;
                  long_nx  = 1'b1;
                  hold_nx  = 1'b1;
               end else begin
                  hold_cnt_nx = hold_cnt + CNT_W'(1);
               end
            end
         end
         LONG_HELD: begin
            if (!btn_s) begin
               state_nx  = RELEASE_DB;
               db_cnt_nx = '0;
            end
         end
         RELEASE_DB: begin
            // A release bounce resumes the hold phase it came from, with hold_cnt intact.
            if (btn_s) begin
               state_nx = o_hold ? LONG_HELD : HELD;
            end else if (i_pls_1k) begin
               if (db_cnt == DB_LAST) begin
                  state_nx   = IDLE;
                  level_nx   = 1'b0;
                  hold_nx    = 1'b0;
                  release_nx = 1'b1;
               end else begin
                  db_cnt_nx = db_cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule
